// File: rtl/arb_pkg.sv
// arb_pkg: FSM state encoding and width default shared by op_unit_arbiter2
package arb_pkg;
  localparam int BW_DEFAULT = 16;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DELIVER   = 3'd4;
endpackage

// File: rtl/op_unit_arbiter2_rise_detect.sv
// rise_detect: one-cycle pulse on a rising edge of D, registered previous level cleared by reset
module rise_detect (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic P
);
  logic d_old;
  // remember last sampled level so a held-high strobe does not retrigger
  always_ff @(posedge CLK) d_old <= RST ? 1'b0 : D;
  assign P = D & ~d_old;
endmodule

// File: rtl/op_unit_arbiter2.sv
// op_unit_arbiter2: shares one ST/RD operation unit between two requesters; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module op_unit_arbiter2
  import arb_pkg::*;
#(
  parameter int BW   = BW_DEFAULT,
  parameter int SCNT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST0,
  input  logic          ST1,
  input  logic [BW-1:0] IN0_0,
  input  logic [BW-1:0] IN1_0,
  input  logic [BW-1:0] IN0_1,
  input  logic [BW-1:0] IN1_1,
  output logic          RD0,
  output logic          RD1,
  output logic [BW-1:0] RES0,
  output logic [BW-1:0] RES1,
  output logic          U_ST,
  output logic [BW-1:0] U_IN0,
  output logic [BW-1:0] U_IN1,
  input  logic          U_RD,
  input  logic [BW-1:0] U_RES
);
  if (SCNT != 2) begin : g_bad_scnt
    $error("op_unit_arbiter2 supports SCNT=2 only");
  end
  logic [2:0]    state;
  logic [1:0]    pend;
  logic          gnt;
  logic          sel;
  logic          p0;
  logic          p1;
  logic [BW-1:0] a0;
  logic [BW-1:0] b0;
  logic [BW-1:0] a1;
  logic [BW-1:0] b1;
  rise_detect u_rise0 (.CLK(CLK), .RST(RST), .D(ST0), .P(p0));
  rise_detect u_rise1 (.CLK(CLK), .RST(RST), .D(ST1), .P(p1));
`ifdef ARB_ROUND_ROBIN_EN
  logic ptr;
  assign sel = &pend ? ptr : pend[1];
  // ptr names the requester favoured on the next tie; it flips away from whoever is issued
  always_ff @(posedge CLK) begin
    if (RST) ptr <= 1'b0;
    else if (state == IDLE && |pend) ptr <= ~sel;
  end
`else
  assign sel = ~pend[0];
`endif
  // request capture plus the issue/wait/deliver sequence toward the shared unit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pend  <= '0;
      gnt   <= 1'b0;
      RD0   <= 1'b1;
      RD1   <= 1'b1;
      RES0  <= '0;
      RES1  <= '0;
      U_ST  <= 1'b0;
      U_IN0 <= '0;
      U_IN1 <= '0;
      a0    <= '0;
      b0    <= '0;
      a1    <= '0;
      b1    <= '0;
    end else begin
      if (p0 && RD0) begin
        a0      <= IN0_0;
        b0      <= IN1_0;
        pend[0] <= 1'b1;
        RD0     <= 1'b0;
      end
      if (p1 && RD1) begin
        a1      <= IN0_1;
        b1      <= IN1_1;
        pend[1] <= 1'b1;
        RD1     <= 1'b0;
      end
      case (state)
        IDLE: if (|pend) begin
          state <= ISSUE;
          gnt   <= sel;
          U_IN0 <= sel ? a1 : a0;
          U_IN1 <= sel ? b1 : b0;
          U_ST  <= 1'b1;
        end
        ISSUE: if (!U_RD) begin
          state <= WAIT_BUSY;
          U_ST  <= 1'b0;
        end
        WAIT_BUSY: state <= WAIT_DONE;
        WAIT_DONE: if (U_RD) begin
          state     <= DELIVER;
          pend[gnt] <= 1'b0;
          if (gnt) begin
            RES1 <= U_RES;
            RD1  <= 1'b1;
          end else begin
            RES0 <= U_RES;
            RD0  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
